// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered reads.
module sync_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_wr_en,
    input  logic                     i_rd_en,
    input  logic                     i_clr_err,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic                     o_almost_full_c,
    output logic                     o_almost_empty_c,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Flags decode the registered count only, so acceptance never depends on same-cycle requests.
    assign o_full_c         = (r_count == CW'(DEPTH));
    assign o_empty_c        = (r_count == CW'(0));
    assign o_almost_full_c  = (r_count >= CW'(AF_THRESH));
    assign o_almost_empty_c = (r_count <= CW'(AE_THRESH));
    assign o_count          = r_count;
    assign o_overflow       = r_overflow;
    assign o_underflow      = r_underflow;

    assign w_wr_acc = i_wr_en && !o_full_c;
    assign w_rd_acc = i_rd_en && !o_empty_c;

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors: a new violation in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && o_full_c) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (i_rd_en && o_empty_c) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
`else
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    assign o_rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model checked every cycle
// plus directed literal checks on reset, ordering, full/empty boundaries, errors and mid-burst reset.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFT   = 14;
    localparam int unsigned AET   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [WIDTH-1:0]  rd_data;
    logic              full, empty, afull, aempty, ovf, udf;
    logic [4:0]        count;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .i_rd_en(rd_en), .i_clr_err(clr_err), .o_rd_data(rd_data),
        .o_full_c(full), .o_empty_c(empty), .o_almost_full_c(afull),
        .o_almost_empty_c(aempty), .o_count(count), .o_overflow(ovf),
        .o_underflow(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue, flags derived from its size.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_rd = '0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            automatic int  sz = m_q.size();
            automatic bit  wa = wr_en && (sz != DEPTH);
            automatic bit  ra = rd_en && (sz != 0);
            if (wr_en && sz == DEPTH) m_ovf = 1'b1;
            else if (clr_err)         m_ovf = 1'b0;
            if (rd_en && sz == 0)     m_udf = 1'b1;
            else if (clr_err)         m_udf = 1'b0;
            if (ra) m_rd = m_q.pop_front();
            if (wa) m_q.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        automatic int sz = m_q.size();
        check("count",        32'(count),  32'(sz));
        check("full",         32'(full),   32'(sz == DEPTH));
        check("empty",        32'(empty),  32'(sz == 0));
        check("almost_full",  32'(afull),  32'(sz >= AFT));
        check("almost_empty", 32'(aempty), 32'(sz <= AET));
        check("overflow",     32'(ovf),    32'(m_ovf));
        check("underflow",    32'(udf),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz != 0) check("rd_data_head", rd_data, m_q[0]);
`else
        check("rd_data", rd_data, m_rd);
`endif
    end

    task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic clr);
        wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_ae",    32'(aempty), 1);
        check("rst_af",    32'(afull),  0);
        check("rst_rd",    rd_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ordered write/read of three words.
        step(1, 32'h11, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_first", rd_data, 32'h11);
`endif
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 0, 0);
        check("cnt3", 32'(count), 3);
        step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rd1", rd_data, 32'h11);
`endif
        step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rd2", rd_data, 32'h22);
`endif
        step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rd3", rd_data, 32'h33);
`endif
        check("empty_after_rd", 32'(empty), 1);

        // Underflow on read while empty.
        step(0, '0, 1, 0);
        check("udf_set",  32'(udf),   1);
        check("udf_cnt",  32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("udf_hold", rd_data, 32'h33);
`endif
        step(0, '0, 0, 1);
        check("udf_clr", 32'(udf), 0);

        // Fill to full with threshold checks along the way.
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h100 + 32'(i), 0, 0);
            check("fill_ae", 32'(aempty), 32'((i + 1) <= 2));
            check("fill_af", 32'(afull),  32'((i + 1) >= 14));
        end
        check("full16",  32'(full),  1);
        check("count16", 32'(count), 16);
        step(1, 32'hDEAD, 0, 0);
        check("ovf_set",   32'(ovf),   1);
        check("ovf_count", 32'(count), 16);
        // Write rejected while full even though a read is accepted.
        step(1, 32'hBEEF, 1, 0);
        check("full_rdwr_cnt", 32'(count), 15);
`ifndef SYNC_FIFO_FWFT_EN
        check("full_rd_head", rd_data, 32'h100);
`endif
        step(0, '0, 0, 1);
        check("ovf_clr", 32'(ovf), 0);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("drain_last", rd_data, 32'h10F);
`endif
        check("drain_empty", 32'(empty), 1);

        // Steady-state streaming at count 8 across pointer wraps.
        for (int i = 0; i < 8; i++) step(1, 32'h200 + 32'(i), 0, 0);
        for (int i = 0; i < 40; i++) step(1, 32'h300 + 32'(i), 1, 0);
        check("stream_cnt", 32'(count), 8);
`ifndef SYNC_FIFO_FWFT_EN
        check("stream_last", rd_data, 32'h31F);
`endif

        // Mid-burst reset at count 5.
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        check("pre_rst_cnt", 32'(count), 5);
        rst = 1'b1;
        #1;
        check("mid_rst_cnt",   32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_ovf",   32'(ovf),   0);
        check("mid_rst_udf",   32'(udf),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 32'hA5, 0, 0);
        check("post_rst_cnt", 32'(count), 1);
        step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("post_rst_rd", rd_data, 32'hA5);
`endif
        check("post_rst_empty", 32'(empty), 1);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 16: entry count; power of two, at least 2.
REQ-003 Parameter AF_THRESH, default DEPTH-2: almost_full threshold, range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2: almost_empty threshold, range 0..DEPTH-1.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_data  input  WIDTH  write word.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request (pop in FWFT mode).
REQ-010 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 rd_data  output  WIDTH  read word.
REQ-012 full  output  1  count equals DEPTH.
REQ-013 empty  output  1  count equals 0.
REQ-014 almost_full  output  1  count >= AF_THRESH.
REQ-015 almost_empty  output  1  count <= AE_THRESH.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky flag: a write was attempted while full.
REQ-018 underflow  output  1  sticky flag: a read was attempted while empty.

Function
REQ-019 Storage SHALL be DEPTH x WIDTH; write and read pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the array index is the low $clog2(DEPTH) bits.
REQ-020 A write SHALL be accepted iff wr_en && !full; an accepted write stores wr_data at the write pointer and increments it.
REQ-021 A read SHALL be accepted iff rd_en && !empty; an accepted read increments the read pointer.
REQ-022 Acceptance SHALL use only the registered flags; when full, a write is rejected even if a read is accepted in the same cycle.
REQ-023 count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-025 Write-to-empty deassertion latency SHALL be 1 cycle; read-to-full deassertion latency SHALL be 1 cycle.
REQ-026 Data SHALL be returned in strict write order across pointer wrap-around.
REQ-027 overflow SHALL set on the cycle after wr_en && full; underflow SHALL set on the cycle after rd_en && empty.
REQ-028 clr_err SHALL clear both error flags on the next edge; when set and clear coincide, set wins.
REQ-029 Rejected requests SHALL change neither the pointers, the count nor the storage.

Reset
REQ-030 Reset SHALL asynchronously force both pointers to 0, count to 0, overflow and underflow to 0, and the registered rd_data to 0.
REQ-031 During and after reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 A reset asserted mid-operation SHALL discard all stored entries; the first access after deassertion SHALL behave as if the FIFO were empty.

Configuration
REQ-034 Macro SYNC_FIFO_FWFT_EN SHALL select the read mode at compile time.
REQ-035 Without the macro (standard mode), rd_data SHALL be registered: it is updated with the head entry on the edge that accepts a read, and holds its value otherwise.
REQ-036 With the macro (first-word fall-through mode), rd_data SHALL combinationally show the head entry whenever !empty, and rd_en SHALL acknowledge (pop) that entry.
REQ-037 With the macro, rd_data is undefined while empty, and there is no reset value requirement on rd_data.

Verification
REQ-038 Reset, then write 0x11, 0x22, 0x33 and read 3 times -> standard mode: rd_data is 0x11, 0x22, 0x33 one cycle after each read; FWFT mode: rd_data is 0x11 one cycle after the first write.
REQ-039 With DEPTH=16, write 16 words -> full=1 and count=16; a 17th wr_en -> overflow=1 and data unchanged; then pulse clr_err -> overflow=0.
REQ-040 Read while empty -> underflow=1, count stays 0, and rd_data holds its previous value in standard mode.
REQ-041 Hold count at 8 with wr_en and rd_en both high for 40 cycles -> count stays 8, and the output stream equals the input stream across two pointer wraps.
REQ-042 With AF_THRESH=14 and AE_THRESH=2, fill from 0 to 16 -> almost_empty=1 while count is 0..2 and almost_full=1 while count is 14..16.
REQ-043 Assert reset with count=5 mid-burst -> count=0, empty=1 and flags cleared immediately; a following write then read returns the new word.
